inc_loop_scheduler: RTL and testbench
=====================================

Name: inc_loop_scheduler

Overview:
- Shares one WIDTH-bit increment datapath among three requesters (a, b, c).
- Each accepted job loads its operand, applies a programmable number of +1 iterations, and returns the result with the requester ID.
- Round-robin arbitration with valid/ready handshakes on both the request and result sides.
- Sits between the operand sources and any consumer of incremented results.

Parameters:
- WIDTH, 3, operand/result width; increment wraps mod 2^WIDTH.
- CNT_W, 4, width of the iteration count; max 2^CNT_W-1 iterations per job.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  3  bit i = requester i has a job (0=a, 1=b, 2=c).
- req_ready  out  3  one-hot accept; transfer when req_valid[i] & req_ready[i].
- a  in  WIDTH  operand of requester 0.
- b  in  WIDTH  operand of requester 1.
- c  in  WIDTH  operand of requester 2.
- cfg_iters  in  CNT_W  increment count, sampled at accept.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_id  out  2  requester ID of the result.

Behaviour:
- Reset: state=IDLE, req_ready=0, busy=0, out_valid=0, out_data=0, out_id=0, acc=0, cnt=0, rr pointer=2 (so requester 0 has first priority).
- Reset asserted mid-job aborts it silently: no out_valid, and the job is lost.
- IDLE state:
  - Priority search starts at pointer+1 mod 3 and wraps.
  - req_ready = one-hot of the first requester with req_valid set; this path is combinational from req_valid and state.
  - On accept: acc <= selected operand, out_id <= ID, cnt <= cfg_iters.
  - If cfg_iters == 0, next state is DONE; otherwise next state is RUN.
- RUN state:
  - Each cycle: acc <= acc+1 (truncated to WIDTH bits), cnt <= cnt-1.
  - When cnt == 1, that increment is the last one; next state is DONE.
  - req_ready = 0.
- DONE state:
  - out_valid=1; out_data=acc and out_id are held stable until out_ready.
  - On out_ready: next state IDLE, pointer <= out_id.
- Latency: with accept at cycle T, out_valid rises at T+N+1 for N ≥ 1, or at T+1 for N = 0.
- Throughput:
  - At least one IDLE cycle between jobs.
  - No new accept in the same cycle as the result handshake.
- Operands and cfg_iters are sampled only on the accept cycle; later changes are ignored.
- A requester may drop req_valid before it is granted; no state changes.
- Back-pressure: out_ready low holds DONE indefinitely; req_ready stays 0.
- Fairness: with all three requesters continuously valid, grants go 0,1,2,0,...; no requester waits more than two jobs.
- out_data and out_id hold their last values in IDLE; valid only while out_valid=1.

Decomposition:
- Shared package inc_sched_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Requester ID constants REQ_A=0, REQ_B=1, REQ_C=2.
  - NUM_REQ=3.
- Sub-module rr_arb3: combinational 3-way round-robin pick.
  - Inputs: req_valid[2:0], pointer[1:0].
  - Outputs: one-hot grant, grant_id, any.
- The top level holds the FSM, acc/cnt registers and the pointer update.

Test Plan:
- Reset, then req_valid=001, a=3, cfg_iters=2, out_ready=1 → req_ready=001 at accept cycle T; out_valid=1 at T+3; out_data=5, out_id=0; back in IDLE at T+4.
- req_valid=010, b=6, cfg_iters=0 → out_valid at T+1 with out_data=6, out_id=1.
- a=7, cfg_iters=1 → out_data=0 (wrap). a=3, cfg_iters=13 → out_data=0 ((3+13) mod 8).
- req_valid=111 held, a=1, b=2, c=3, cfg_iters=1, out_ready=1 → grant order 0,1,2,0; results (id, data) = (0,2), (1,3), (2,4), (0,2).
- DONE reached with out_ready=0 for 5 cycles while req_valid=111 → out_valid, out_data, out_id stable; req_ready=000; busy=1. Release → one handshake, then the next grant follows the round-robin order.
- rst pulsed at the 2nd RUN cycle of a cfg_iters=6 job → the following cycle busy=0, out_valid=0. A subsequent req_valid=100 with c=4, cfg_iters=3 → out_data=7, out_id=2, with no stale result from the aborted job.

Source files
------------

// File: rtl/inc_sched_pkg.sv
// Shared types and constants for the increment-loop scheduler.
// Imported by the arbiter and the scheduler top.
package inc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int NUM_REQ = 3;

   localparam logic [1:0] REQ_A = 2'd0;
   localparam logic [1:0] REQ_B = 2'd1;
   localparam logic [1:0] REQ_C = 2'd2;

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin pick, purely combinational.
// Search starts just after the pointer and wraps.
module rr_arb3
   import inc_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [1:0]         pointer,
   output logic [NUM_REQ-1:0] grant,
   output logic [1:0]         grant_id,
   output logic               any
);

   logic [1:0] s0;
   logic [1:0] s1;
   logic [1:0] s2;

   // search order derived from the last-served requester
   always_comb begin
      s0 = REQ_A;
      s1 = REQ_B;
      s2 = REQ_C;
      unique case (pointer)
         REQ_A: begin
            s0 = REQ_B;
            s1 = REQ_C;
            s2 = REQ_A;
         end
         REQ_B: begin
            s0 = REQ_C;
            s1 = REQ_A;
            s2 = REQ_B;
         end
         default: begin
            s0 = REQ_A;
            s1 = REQ_B;
            s2 = REQ_C;
         end
      endcase
   end

   // first valid requester in search order wins
   always_comb begin
      any      = |req_valid;
      grant_id = s0;
      if (req_valid[s0]) begin
         grant_id = s0;
      end else if (req_valid[s1]) begin
         grant_id = s1;
      end else if (req_valid[s2]) begin
         grant_id = s2;
      end
      grant = any ? NUM_REQ'(3'b001 << grant_id) : '0;
   end

endmodule

// File: rtl/inc_loop_scheduler.sv
// Shares one increment datapath among three requesters.
// Jobs run N increments then wait in DONE for the consumer.
module inc_loop_scheduler
   import inc_sched_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         req_valid,
   output logic [2:0]         req_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   input  logic [CNT_W-1:0]   cfg_iters,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_id
);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         id_q;
   logic [1:0]         ptr_q;
   logic [2:0]         grant;
   logic [1:0]         grant_id;
   logic               any;
   logic               accept;
   logic [WIDTH-1:0]   operand;

   rr_arb3 u_arb (
      .req_valid (req_valid),
      .pointer   (ptr_q),
      .grant     (grant),
      .grant_id  (grant_id),
      .any       (any)
   );

   assign accept    = (state_q == IDLE) && any;
   assign req_ready = (state_q == IDLE) ? grant : 3'b000;
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = acc_q;
   assign out_id    = id_q;

   // operand of the granted requester
   always_comb begin
      operand = a;
      unique case (grant_id)
         REQ_A:   operand = a;
         REQ_B:   operand = b;
         default: operand = c;
      endcase
   end

   // next-state: zero-iteration jobs skip straight to DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (cfg_iters == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, datapath and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         id_q    <= REQ_A;
         ptr_q   <= REQ_C;
      end else begin
         state_q <= state_d;
         if (accept) begin
            acc_q <= operand;
            id_q  <= grant_id;
            cnt_q <= cfg_iters;
         end else if (state_q == RUN) begin
            acc_q <= acc_q + WIDTH'(1);
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if ((state_q == DONE) && out_ready) begin
            ptr_q <= id_q;
         end
      end
   end

endmodule

// File: tb/tb_inc_loop_scheduler.sv
// Self-checking bench for inc_loop_scheduler.
// Table vectors, corner sequences and a random run against a job model.
module tb_inc_loop_scheduler;

   logic       clk;
   logic       rst;
   logic [2:0] req_valid;
   logic [2:0] req_ready;
   logic [2:0] a;
   logic [2:0] b;
   logic [2:0] c;
   logic [3:0] cfg_iters;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_data;
   logic [1:0] out_id;

   inc_loop_scheduler #(.WIDTH(3), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .cfg_iters (cfg_iters),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // job-level reference model
   bit       m_busy = 1'b0;
   int       m_wait = 0;
   int       m_data = 0;
   int       m_id   = 0;
   int       m_ptr  = 2;
   int       cyc    = 0;
   int       acc_cyc = 0;
   bit       seen_acc = 1'b0;
   int       hs_count = 0;
   int       last_d = 0;
   int       last_i = 0;
   int       last_lat = 0;
   int       hs_ids[$];
   int       hs_data[$];

   typedef struct {
      logic [2:0] rv;
      logic [2:0] av;
      logic [2:0] bv;
      logic [2:0] cv;
      logic [3:0] n;
      int         id;
      int         data;
      int         lat;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] rr_pick(input int p, input logic [2:0] rv);
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (p + k) % 3;
         if (rv[i]) return 3'(1 << i);
      end
      return 3'b000;
   endfunction

   // one clock: check outputs, advance model, move to next negedge
   task automatic step();
      logic [2:0] er;
      bit         ev;
      int         idx;
      int         op;
      #1;
      er = m_busy ? 3'b000 : rr_pick(m_ptr, req_valid);
      ev = m_busy && (m_wait == 0);
      chk("req_ready", int'(req_ready), int'(er));
      chk("busy", int'(busy), int'(m_busy));
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev) begin
         chk("out_data", int'(out_data), m_data);
         chk("out_id", int'(out_id), m_id);
      end
      seen_acc = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_wait = 0;
         m_ptr  = 2;
      end else if (er != 3'b000) begin
         idx = er[0] ? 0 : (er[1] ? 1 : 2);
         op  = (idx == 0) ? int'(a) : ((idx == 1) ? int'(b) : int'(c));
         m_busy  = 1'b1;
         m_id    = idx;
         m_data  = (op + int'(cfg_iters)) % 8;
         m_wait  = int'(cfg_iters);
         acc_cyc = cyc;
         seen_acc = 1'b1;
      end else if (m_busy) begin
         if (m_wait > 0) begin
            m_wait--;
         end else if (out_ready) begin
            last_d   = int'(out_data);
            last_i   = int'(out_id);
            last_lat = cyc - acc_cyc;
            hs_ids.push_back(last_i);
            hs_data.push_back(last_d);
            hs_count++;
            m_busy = 1'b0;
            m_ptr  = m_id;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 3'b000;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_job(input logic [2:0] rv, input logic [2:0] av,
                          input logic [2:0] bv, input logic [2:0] cv,
                          input logic [3:0] n);
      int start;
      bit done;
      start     = hs_count;
      done      = 1'b0;
      req_valid = rv;
      a         = av;
      b         = bv;
      c         = cv;
      cfg_iters = n;
      out_ready = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         step();
         if (seen_acc) begin
            req_valid = 3'b000;
            a         = 3'($urandom);
            b         = 3'($urandom);
            c         = 3'($urandom);
            cfg_iters = 4'($urandom);
         end
         if (hs_count != start) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL job_timeout: got no result expected one (cycle %0d)", cyc);
      end
   endtask

   initial begin
      int start;
      int k;
      rst       = 1'b1;
      req_valid = 3'b000;
      a         = '0;
      b         = '0;
      c         = '0;
      cfg_iters = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_id", int'(out_id), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      req_valid = 3'b111;
      #1;
      chk("rst_first_prio", int'(req_ready), 1);
      req_valid = 3'b000;
      @(negedge clk);

      vecs[0] = '{3'b001, 3'd3, 3'd0, 3'd0, 4'd2,  0, 5, 3};
      vecs[1] = '{3'b010, 3'd0, 3'd6, 3'd0, 4'd0,  1, 6, 1};
      vecs[2] = '{3'b001, 3'd7, 3'd0, 3'd0, 4'd1,  0, 0, 2};
      vecs[3] = '{3'b001, 3'd3, 3'd0, 3'd0, 4'd13, 0, 0, 14};
      vecs[4] = '{3'b100, 3'd0, 3'd0, 3'd5, 4'd15, 2, 4, 16};
      for (int i = 0; i < 5; i++) begin
         run_job(vecs[i].rv, vecs[i].av, vecs[i].bv, vecs[i].cv, vecs[i].n);
         chk("vec_data", last_d, vecs[i].data);
         chk("vec_id", last_i, vecs[i].id);
         chk("vec_latency", last_lat, vecs[i].lat);
         step();
         chk("vec_idle_after", int'(busy), 0);
      end

      // fairness with all three requesters held valid
      do_reset();
      hs_ids.delete();
      hs_data.delete();
      start     = hs_count;
      req_valid = 3'b111;
      a         = 3'd1;
      b         = 3'd2;
      c         = 3'd3;
      cfg_iters = 4'd1;
      out_ready = 1'b1;
      k = 0;
      while (hs_count < start + 4 && k < 40) begin
         step();
         k++;
      end
      chk("rr_count", hs_count - start, 4);
      if (hs_ids.size() == 4) begin
         chk("rr_id0", hs_ids[0], 0);
         chk("rr_d0", hs_data[0], 2);
         chk("rr_id1", hs_ids[1], 1);
         chk("rr_d1", hs_data[1], 3);
         chk("rr_id2", hs_ids[2], 2);
         chk("rr_d2", hs_data[2], 4);
         chk("rr_id3", hs_ids[3], 0);
         chk("rr_d3", hs_data[3], 2);
      end

      // back-pressure in DONE
      do_reset();
      req_valid = 3'b111;
      out_ready = 1'b0;
      k = 0;
      while (!out_valid && k < 10) begin
         step();
         k++;
      end
      chk("bp_reached", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_data", int'(out_data), 2);
         chk("bp_id", int'(out_id), 0);
         chk("bp_rdy", int'(req_ready), 0);
         chk("bp_busy", int'(busy), 1);
      end
      out_ready = 1'b1;
      start = hs_count;
      step();
      chk("bp_handshake", hs_count - start, 1);
      #1;
      chk("bp_next_grant", int'(req_ready), 2);
      step();

      // reset during RUN drops the job
      do_reset();
      req_valid = 3'b001;
      a         = 3'd0;
      cfg_iters = 4'd6;
      out_ready = 1'b1;
      step();
      req_valid = 3'b000;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(out_valid), 0);
      @(negedge clk);
      cyc++;
      start = hs_count;
      repeat (8) step();
      chk("abort_no_stale", hs_count - start, 0);
      run_job(3'b100, 3'd1, 3'd1, 3'd4, 4'd3);
      chk("abort_next_data", last_d, 7);
      chk("abort_next_id", last_i, 2);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         req_valid = 3'($urandom_range(0, 7));
         a         = 3'($urandom);
         b         = 3'($urandom);
         c         = 3'($urandom);
         cfg_iters = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
